// File: rtl/radix4_op_scheduler.sv
// Round-robin scheduler sharing one radix-4 arithmetic core between two requesters:
// sequences core reset/start, waits for done under a watchdog, returns a tagged response.
//
// state | meaning
// IDLE  | arbitrate; grant and latch operands on handshake
// RST   | core_reset high for one cycle
// GAP   | one quiet cycle between core reset and start
// START | core_start high for START_LEN cycles
// WAIT  | wait for core_done, watchdog counting
// RESP  | hold response until rsp_ready
module radix4_op_scheduler #(
    parameter int WIDTH     = 16,
    parameter int START_LEN = 3,
    parameter int TIMEOUT   = 63
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               req0_valid,
    output logic               req0_ready,
    input  logic [WIDTH-1:0]   req0_a,
    input  logic [WIDTH-1:0]   req0_b,
    input  logic               req1_valid,
    output logic               req1_ready,
    input  logic [WIDTH-1:0]   req1_a,
    input  logic [WIDTH-1:0]   req1_b,
    output logic               core_reset,
    output logic               core_start,
    output logic [WIDTH-1:0]   core_a,
    output logic [WIDTH-1:0]   core_b,
    input  logic               core_done,
    input  logic [2*WIDTH-1:0] core_result,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [2*WIDTH-1:0] rsp_result,
    output logic               rsp_id,
    output logic               rsp_err,
    output logic               busy
);

    localparam int CNT_MAX = (START_LEN > TIMEOUT) ? START_LEN : TIMEOUT;
    localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;
    localparam logic [CW-1:0] START_LAST   = CW'(START_LEN - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, RST, GAP, START, WAIT, RESP} state_t;

    state_t             state, state_nxt;
    logic [CW-1:0]      cnt, cnt_nxt;
    logic               last_grant, last_grant_nxt;
    logic [WIDTH-1:0]   core_a_nxt, core_b_nxt;
    logic [2*WIDTH-1:0] rsp_result_nxt;
    logic               rsp_id_nxt, rsp_err_nxt;
    logic               grant_any, grant_id;

    // With both requesting, the one not served last wins.
    assign grant_any = req0_valid | req1_valid;
    assign grant_id  = (req0_valid && req1_valid) ? ~last_grant : req1_valid;

    assign req0_ready = (state == IDLE) && grant_any && !grant_id;
    assign req1_ready = (state == IDLE) && grant_any &&  grant_id;
    assign busy       = (state != IDLE);

    always_comb begin
        state_nxt      = state;
        cnt_nxt        = cnt;
        last_grant_nxt = last_grant;
        core_a_nxt     = core_a;
        core_b_nxt     = core_b;
        rsp_result_nxt = rsp_result;
        rsp_id_nxt     = rsp_id;
        rsp_err_nxt    = rsp_err;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    core_a_nxt     = grant_id ? req1_a : req0_a;
                    core_b_nxt     = grant_id ? req1_b : req0_b;
                    rsp_id_nxt     = grant_id;
                    last_grant_nxt = grant_id;
                    state_nxt      = RST;
                end
            end
            RST: state_nxt = GAP;
            GAP: begin
                cnt_nxt   = '0;
                state_nxt = START;
            end
            START: begin
                if (cnt == START_LAST) begin
                    cnt_nxt   = '0;
                    state_nxt = WAIT;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            WAIT: begin
                // done takes priority over a coincident watchdog expiry
                if (core_done) begin
                    rsp_result_nxt = core_result;
                    rsp_err_nxt    = 1'b0;
                    state_nxt      = RESP;
                end else if (cnt == TIMEOUT_LAST) begin
                    rsp_result_nxt = '0;
                    rsp_err_nxt    = 1'b1;
                    state_nxt      = RESP;
                end else begin
                    cnt_nxt = cnt + CW'(1);
                end
            end
            RESP: begin
                if (rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Registered outputs follow the state being entered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            last_grant <= 1'b1;
            core_reset <= 1'b1;
            core_start <= 1'b0;
            core_a     <= '0;
            core_b     <= '0;
            rsp_valid  <= 1'b0;
            rsp_result <= '0;
            rsp_id     <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            last_grant <= last_grant_nxt;
            core_reset <= (state_nxt == RST);
            core_start <= (state_nxt == START);
            core_a     <= core_a_nxt;
            core_b     <= core_b_nxt;
            rsp_valid  <= (state_nxt == RESP);
            rsp_result <= rsp_result_nxt;
            rsp_id     <= rsp_id_nxt;
            rsp_err    <= rsp_err_nxt;
        end
    end

endmodule
